alu_res_fifo: RTL and testbench
===============================

# alu_res_fifo

Result buffer sitting directly downstream of `alu`. Each cycle the issue control marks a valid result, the block captures the 32-bit `res` word into a small FIFO. It presents the words in order to the consumer (write-back or output stage) with a valid/ready handshake. It decouples ALU issue from consumer stalls and keeps a sticky flag when a result is lost because the buffer was full.

## Interface
- `WIDTH`, 32, data word width; matches `alu` `res`.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_data` holds a result to capture this cycle.
- `in_ready`  output  1  buffer can accept a word this cycle (= not full).
- `in_data`  input  WIDTH  result word, driven from `alu` `res`.
- `out_valid`  output  1  `out_data` holds the oldest buffered word.
- `out_ready`  input  1  consumer takes `out_data` this cycle.
- `out_data`  output  WIDTH  oldest buffered word.
- `count`  output  $clog2(DEPTH)+1  number of entries currently held, 0..DEPTH.
- `drop`  output  1  sticky: at least one result was offered while full.
- `clr_drop`  input  1  synchronous clear of `drop`.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH)+1 bits.
  - Index is the low bits; the MSB is the wrap bit.
  - Empty when `wp == rp`. Full when the index bits are equal and the wrap bits differ.
- Push = `in_valid && in_ready`. On push: `mem[wp] <= in_data`, `wp <= wp + 1`.
- Pop = `out_valid && out_ready`. On pop: `rp <= rp + 1`.
- `in_ready = !full`. This is combinational from state only, never from `out_ready`.
- No push-through when full: a pop in the same cycle does not free a slot for that cycle's input.
- `out_valid = !empty`. `out_data = mem[rp index]`, a combinational read of registered state.
  - `out_data` is don't-care when `out_valid` is 0.
- `count = wp - rp`, modulo 2^($clog2(DEPTH)+1).
  - Push only: count +1. Pop only: count −1. Both together: count unchanged.
- Drop:
  - `in_valid && !in_ready` sets `drop` at the next edge. The word is discarded and pointers are unchanged.
  - `clr_drop` clears `drop` at the next edge.
  - If a drop event and `clr_drop` occur in the same cycle, set wins and `drop` ends at 1.
- Consumer contract: once `out_valid` is 1, `out_data` stays stable until popped. Pops only remove data and pushes only append, so this holds without extra logic.
- Reset (asynchronous assert, deassert synchronized externally):
  - `wp`, `rp` = 0 and `drop` = 0.
  - Hence `out_valid` = 0, `in_ready` = 1, `count` = 0.
  - `mem` is not reset.
  - Reset mid-operation discards all held words immediately; nothing is popped afterwards.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N. There is no same-cycle fall-through when empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- `in_ready` falls in the cycle after the push that makes count = DEPTH. It rises in the cycle after the first pop from full.
- `count` and `drop` are updated at the same edge as the pointers.
- Wrap-around: pointers roll over from 2·DEPTH−1 to 0 with no bubble and no data corruption.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready` = 0 → `count` reads 1, 2, 3; `out_data` = 0x11 throughout; `in_ready` = 1.
- Continue: push 0x44 → `count` = 4, `in_ready` = 0. Then offer 0x55 → word discarded, `drop` = 1, `count` stays 4. Raise `out_ready` → pops in order 0x11, 0x22, 0x33, 0x44; 0x55 never appears.
- Hold `in_valid` = 1 and `out_ready` = 1 for 20 cycles with incrementing data 0..19, starting from count 1 → `count` constant at 1, outputs in order with no gaps, pointers wrap at least twice, `drop` stays 0.
- At full, assert push and pop in the same cycle → pop occurs, push is rejected, `drop` sets, `count` = 3.
- With `drop` = 1, assert `clr_drop` in the same cycle as a new drop event → `drop` = 1. Then `clr_drop` alone → `drop` = 0.
- With count = 3, assert `rst` asynchronously mid-cycle → `out_valid` = 0, `count` = 0, `in_ready` = 1 before the next edge. After release, push 0xAB → the next pop returns 0xAB.

Source files
------------

// File: rtl/alu_res_fifo_if.sv
// Handshake bundle between the ALU result stage, the result FIFO and its consumer.
// The slave side is the FIFO; the master side is whatever drives results in and drains them.
interface alu_res_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     drop;
  logic                     clr_drop;

  modport slave (
    input  in_valid, in_data, out_ready, clr_drop,
    output in_ready, out_valid, out_data, count, drop
  );

  modport master (
    output in_valid, in_data, out_ready, clr_drop,
    input  in_ready, out_valid, out_data, count, drop
  );
endinterface

// File: rtl/alu_res_fifo.sv
// Small in-order result buffer behind the ALU: captures valid results, hands them to the
// consumer over valid/ready, and keeps a sticky flag when a result arrives while full.
module alu_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_res_fifo_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             drop_q;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop_set;

  // Full means same slot but a different lap; the extra wrap bit is what tells it apart from empty.
  // NOTE: every signal in an always_comb is assigned on every path, so no latch can be inferred.
  always_comb begin
    empty    = (wp == rp);
    full     = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    push     = bus.in_valid && !full;
    pop      = !empty && bus.out_ready;
    drop_set = bus.in_valid && full;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      // A new loss must never be hidden by a simultaneous clear.
      if (drop_set)          drop_q <= 1'b1;
      else if (bus.clr_drop) drop_q <= 1'b0;
    end
  end

  // NOTE: storage has no reset; empty pointers already mask stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= bus.in_data;
  end

  // in_ready depends only on held state, never on out_ready, so a full buffer rejects
  // the input even when the consumer drains an entry in the same cycle.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rp[AW-1:0]];
  assign bus.count     = wp - rp;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_alu_res_fifo.sv
// Bench for alu_res_fifo: directed scenarios followed by random traffic, all compared
// against a queue-based model of the buffer.
module tb_alu_res_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_res_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_res_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q_m [$];
  logic             drop_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.clr_drop  = c;
  endtask

  // Compare outputs to the model, then advance both across one rising edge.
  task automatic step();
    logic do_push;
    logic do_pop;
    check("out_valid", 32'(bus.out_valid), 32'(q_m.size() > 0));
    check("in_ready",  32'(bus.in_ready),  32'(q_m.size() < DEPTH));
    check("count",     32'(bus.count),     32'(q_m.size()));
    check("drop",      32'(bus.drop),      32'(drop_m));
    if (q_m.size() > 0) check("out_data", bus.out_data, q_m[0]);
    do_push = bus.in_valid && (q_m.size() < DEPTH);
    do_pop  = bus.out_ready && (q_m.size() > 0);
    if (bus.in_valid && q_m.size() == DEPTH) drop_m = 1'b1;
    else if (bus.clr_drop)                   drop_m = 1'b0;
    if (do_pop)  void'(q_m.pop_front());
    if (do_push) q_m.push_back(bus.in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill with the consumer stalled.
    drive(1'b1, 32'h11, 1'b0, 1'b0); step();
    drive(1'b1, 32'h22, 1'b0, 1'b0); step();
    drive(1'b1, 32'h33, 1'b0, 1'b0); step();
    check("count_after_3", 32'(bus.count), 32'd3);
    drive(1'b1, 32'h44, 1'b0, 1'b0); step();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h55, 1'b0, 1'b0); step();
    check("drop_on_full", 32'(bus.drop), 32'd1);
    check("count_kept_4", 32'(bus.count), 32'd4);
    // Drain in order; 0x55 must not appear.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0); step();
    end
    drive(1'b0, '0, 1'b0, 1'b1); step();

    // Sustained push+pop from count 1 with wrapping pointers.
    drive(1'b1, 32'hF0, 1'b0, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0); step();
      check("stream_count", 32'(bus.count), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0); step();

    // Full with simultaneous push and pop: pop happens, push is rejected.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0); step();
    end
    drive(1'b1, 32'hBEEF, 1'b1, 1'b0); step();
    check("full_pushpop_count", 32'(bus.count), 32'd3);
    check("full_pushpop_drop",  32'(bus.drop),  32'd1);

    // Set wins over clear, then clear alone.
    drive(1'b1, 32'hC0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hC1, 1'b0, 1'b1); step();
    check("set_beats_clr", 32'(bus.drop), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1); step();
    check("clr_alone", 32'(bus.drop), 32'd0);

    // Reduce to count 3, then asynchronous reset mid-cycle.
    drive(1'b0, '0, 1'b1, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); step();
    check("pre_rst_count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_drop",      32'(bus.drop),      32'd0);
    q_m.delete();
    drop_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 32'hAB, 1'b0, 1'b0); step();
    check("post_rst_data", bus.out_data, 32'hAB);
    drive(1'b0, '0, 1'b1, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); step();

    // Random traffic with a bias that changes every block, to visit empty and full.
    for (int blk = 0; blk < 20; blk++) begin
      int in_bias;
      int out_bias;
      in_bias  = $urandom_range(1, 7);
      out_bias = $urandom_range(1, 7);
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 7) < in_bias, $urandom,
              $urandom_range(0, 7) < out_bias, $urandom_range(0, 15) == 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
